// File: rtl/rom_loader.sv
// Boot ROM loader: copies ROM bytes into RAM one at a time, then releases the CPU.
// Each byte takes a FETCH cycle (sample ROM) and at least one WRITE cycle (hold the
// RAM request until ram_ready). The load ends in DONE when the byte flagged by
// rom_done has been written, or in ERROR if MAX_BYTES bytes go by without it.
module rom_loader #(
    parameter logic [31:0] RAM_BASE   = 32'd0,
    parameter logic [31:0] MAX_BYTES  = 32'd65536,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic [31:0] rom_address,
    input  logic [7:0]  rom_byte,
    input  logic        rom_done,
    output logic [31:0] ram_address,
    output logic [7:0]  ram_data,
    output logic        ram_write_enable,
    input  logic        ram_ready,
    output logic        cpu_reset,
    output logic        load_done,
    output logic        load_error,
    output logic [31:0] byte_count,
    output logic [7:0]  checksum
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWrite,
        StDone,
        StError
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] count_q, count_d;
    logic [7:0]  sum_q, sum_d;
    logic [7:0]  data_q, data_d;
    logic        last_q, last_d;
    // Set by reset when AUTO_START, so IDLE leaves on the first cycle after reset.
    logic        auto_q, auto_d;

    // Registered status outputs, derived from the next state so they line up with state_q.
    logic        we_q;
    logic        cpu_reset_q;
    logic        done_q;
    logic        error_q;

    logic [31:0] count_inc;

    assign count_inc = count_q + 32'd1;

    // Next-state, counter, checksum and capture-register logic.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        sum_d   = sum_q;
        data_d  = data_q;
        last_d  = last_q;
        auto_d  = auto_q;

        case (state_q)
            StIdle: begin
                if (start || auto_q) begin
                    state_d = StFetch;
                    count_d = 32'd0;
                    sum_d   = 8'd0;
                    auto_d  = 1'b0;
                end
            end

            StFetch: begin
                // rom_done is only meaningful here; later changes on it are ignored.
                data_d  = rom_byte;
                last_d  = rom_done;
                state_d = StWrite;
            end

            StWrite: begin
                if (ram_ready) begin
                    count_d = count_inc;
                    sum_d   = sum_q + data_q;
                    if (last_q) begin
                        state_d = StDone;
                    end else if (count_inc == MAX_BYTES) begin
                        state_d = StError;
                    end else begin
                        state_d = StFetch;
                    end
                end
            end

            StDone, StError: begin
                if (start) begin
                    state_d = StFetch;
                    count_d = 32'd0;
                    sum_d   = 8'd0;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset aborts any load and wins over all inputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            count_q     <= 32'd0;
            sum_q       <= 8'd0;
            data_q      <= 8'd0;
            last_q      <= 1'b0;
            auto_q      <= AUTO_START;
            we_q        <= 1'b0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            sum_q       <= sum_d;
            data_q      <= data_d;
            last_q      <= last_d;
            auto_q      <= auto_d;
            we_q        <= (state_d == StWrite);
            cpu_reset_q <= (state_d != StDone);
            done_q      <= (state_d == StDone);
            error_q     <= (state_d == StError);
        end
    end

    assign rom_address      = count_q;
    assign ram_address      = RAM_BASE + count_q;
    assign ram_data         = data_q;
    assign ram_write_enable = we_q;
    assign cpu_reset        = cpu_reset_q;
    assign load_done        = done_q;
    assign load_error       = error_q;
    assign byte_count       = count_q;
    assign checksum         = sum_q;

endmodule

// File: tb/tb_rom_loader.sv
// Bench for rom_loader: two instances (default parameters, and RAM_BASE=0x100 with
// MAX_BYTES=8) share a ROM image, each with its own done index and RAM stall pattern.
// Expected results come from a simple per-load model of bytes, sums and cycle costs.
module tb_rom_loader;

    localparam logic [31:0] BaseA = 32'd0;
    localparam logic [31:0] MaxA  = 32'd65536;
    localparam logic [31:0] BaseB = 32'h100;
    localparam logic [31:0] MaxB  = 32'd8;

    logic clk;
    logic reset;
    logic start;
    logic mon_clr;

    logic [31:0] rom_address_a, ram_address_a, byte_count_a;
    logic [31:0] rom_address_b, ram_address_b, byte_count_b;
    logic [7:0]  rom_byte_a, ram_data_a, checksum_a;
    logic [7:0]  rom_byte_b, ram_data_b, checksum_b;
    logic        rom_done_a, we_a, cpu_reset_a, done_a, error_a;
    logic        rom_done_b, we_b, cpu_reset_b, done_b, error_b;

    // ROM image, per-instance done index and per-write stall counts.
    logic [7:0]  rom_mem [64];
    logic [31:0] last_idx [2];
    int unsigned stall_tab [2][64];
    logic [31:0] base_tab [2];
    logic [31:0] max_tab [2];

    // Monitor state.
    logic        ready [2];
    int unsigned acc [2];
    int unsigned cyc [2];
    int unsigned end_cyc [2];
    bit          ended [2];
    int unsigned stall_left [2];

    logic        we_s [2];
    logic [31:0] waddr_s [2];
    logic [7:0]  wdata_s [2];
    logic        done_s [2];
    logic        err_s [2];

    int n_cmp;
    int n_bad;

    assign rom_byte_a = rom_mem[rom_address_a[5:0]];
    assign rom_byte_b = rom_mem[rom_address_b[5:0]];
    assign rom_done_a = (rom_address_a == last_idx[0]);
    assign rom_done_b = (rom_address_b == last_idx[1]);

    assign we_s[0]    = we_a;
    assign we_s[1]    = we_b;
    assign waddr_s[0] = ram_address_a;
    assign waddr_s[1] = ram_address_b;
    assign wdata_s[0] = ram_data_a;
    assign wdata_s[1] = ram_data_b;
    assign done_s[0]  = done_a;
    assign done_s[1]  = done_b;
    assign err_s[0]   = error_a;
    assign err_s[1]   = error_b;

    rom_loader #(
        .RAM_BASE  (BaseA),
        .MAX_BYTES (MaxA),
        .AUTO_START(1'b1)
    ) u_dut_a (
        .clock           (clk),
        .reset           (reset),
        .start           (start),
        .rom_address     (rom_address_a),
        .rom_byte        (rom_byte_a),
        .rom_done        (rom_done_a),
        .ram_address     (ram_address_a),
        .ram_data        (ram_data_a),
        .ram_write_enable(we_a),
        .ram_ready       (ready[0]),
        .cpu_reset       (cpu_reset_a),
        .load_done       (done_a),
        .load_error      (error_a),
        .byte_count      (byte_count_a),
        .checksum        (checksum_a)
    );

    rom_loader #(
        .RAM_BASE  (BaseB),
        .MAX_BYTES (MaxB),
        .AUTO_START(1'b1)
    ) u_dut_b (
        .clock           (clk),
        .reset           (reset),
        .start           (start),
        .rom_address     (rom_address_b),
        .rom_byte        (rom_byte_b),
        .rom_done        (rom_done_b),
        .ram_address     (ram_address_b),
        .ram_data        (ram_data_b),
        .ram_write_enable(we_b),
        .ram_ready       (ready[1]),
        .cpu_reset       (cpu_reset_b),
        .load_done       (done_b),
        .load_error      (error_b),
        .byte_count      (byte_count_b),
        .checksum        (checksum_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // RAM stub and write monitor, on the falling edge: checks every requested write
    // against the ROM image, plays the stall pattern on ready, counts cycles to DONE/ERROR.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (mon_clr || reset) begin
                    acc[k]        = 0;
                    cyc[k]        = 0;
                    end_cyc[k]    = 0;
                    ended[k]      = 1'b0;
                    stall_left[k] = stall_tab[k][0];
                    ready[k]      = 1'b1;
                end else begin
                    cyc[k]++;
                    if (!ended[k] && (done_s[k] || err_s[k])) begin
                        ended[k]   = 1'b1;
                        end_cyc[k] = cyc[k];
                    end
                    if (we_s[k]) begin
                        check_eq($sformatf("wr_addr%0d", k), waddr_s[k], base_tab[k] + acc[k]);
                        check_eq($sformatf("wr_data%0d", k), {24'd0, wdata_s[k]},
                                 {24'd0, rom_mem[acc[k] & 63]});
                        if (stall_left[k] > 0) begin
                            ready[k] = 1'b0;
                            stall_left[k]--;
                        end else begin
                            ready[k] = 1'b1;
                            acc[k]++;
                            stall_left[k] = stall_tab[k][acc[k] & 63];
                        end
                    end else begin
                        ready[k] = 1'($urandom_range(0, 1));
                    end
                end
            end
        end
    end

    task automatic wait_end(input int budget);
        bit fin;
        fin = 1'b0;
        for (int c = 0; c < budget && !fin; c++) begin
            @(posedge clk);
            #2;
            fin = ended[0] && ended[1];
        end
        check_eq("load_finished", {31'd0, fin}, 32'd1);
    endtask

    // Model of one complete load, compared after a few idle cycles so stray writes show.
    task automatic check_result();
        int unsigned n;
        int unsigned stalls;
        logic [7:0]  sum;
        bit          err;
        logic [31:0] bc;
        logic [7:0]  cs;
        logic        cr;
        logic        dn;
        logic        er;
        repeat (4) @(posedge clk);
        #2;
        for (int k = 0; k < 2; k++) begin
            err    = (last_idx[k] >= max_tab[k]);
            n      = err ? max_tab[k] : last_idx[k] + 1;
            sum    = 8'd0;
            stalls = 0;
            for (int i = 0; i < int'(n); i++) begin
                sum    = sum + rom_mem[i & 63];
                stalls = stalls + stall_tab[k][i & 63];
            end
            bc = (k == 0) ? byte_count_a : byte_count_b;
            cs = (k == 0) ? checksum_a : checksum_b;
            cr = (k == 0) ? cpu_reset_a : cpu_reset_b;
            dn = (k == 0) ? done_a : done_b;
            er = (k == 0) ? error_a : error_b;
            check_eq($sformatf("end_cycle%0d", k), end_cyc[k], 1 + 2 * n + stalls);
            check_eq($sformatf("writes%0d", k), acc[k], n);
            check_eq($sformatf("byte_count%0d", k), bc, n);
            check_eq($sformatf("checksum%0d", k), {24'd0, cs}, {24'd0, sum});
            check_eq($sformatf("load_done%0d", k), {31'd0, dn}, {31'd0, !err});
            check_eq($sformatf("load_error%0d", k), {31'd0, er}, {31'd0, err});
            check_eq($sformatf("cpu_reset%0d", k), {31'd0, cr}, {31'd0, err});
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_we_a"}, {31'd0, we_a}, 32'd0);
        check_eq({tag, "_we_b"}, {31'd0, we_b}, 32'd0);
        check_eq({tag, "_cpu_reset_a"}, {31'd0, cpu_reset_a}, 32'd1);
        check_eq({tag, "_cpu_reset_b"}, {31'd0, cpu_reset_b}, 32'd1);
        check_eq({tag, "_done_a"}, {31'd0, done_a}, 32'd0);
        check_eq({tag, "_error_b"}, {31'd0, error_b}, 32'd0);
        check_eq({tag, "_count_a"}, byte_count_a, 32'd0);
        check_eq({tag, "_count_b"}, byte_count_b, 32'd0);
        check_eq({tag, "_sum_a"}, {24'd0, checksum_a}, 32'd0);
        check_eq({tag, "_sum_b"}, {24'd0, checksum_b}, 32'd0);
        check_eq({tag, "_rom_addr_a"}, rom_address_a, 32'd0);
    endtask

    // Pulse start from DONE/ERROR; cpu_reset must be back up right after that edge.
    task automatic start_load();
        @(posedge clk);
        #2;
        start   = 1'b1;
        mon_clr = 1'b1;
        @(posedge clk);
        #2;
        start   = 1'b0;
        mon_clr = 1'b0;
        check_eq("restart_cpu_reset_a", {31'd0, cpu_reset_a}, 32'd1);
        check_eq("restart_cpu_reset_b", {31'd0, cpu_reset_b}, 32'd1);
    endtask

    task automatic release_reset();
        reset   = 1'b0;
        mon_clr = 1'b1;
        @(posedge clk);
        #2;
        mon_clr = 1'b0;
    endtask

    task automatic randomize_load(input int unsigned max_last_a, input int unsigned max_last_b);
        for (int i = 0; i < 64; i++) begin
            rom_mem[i] = 8'($urandom);
            for (int k = 0; k < 2; k++) begin
                stall_tab[k][i] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            end
        end
        last_idx[0] = 32'($urandom_range(0, max_last_a));
        last_idx[1] = 32'($urandom_range(0, max_last_b));
    endtask

    initial begin
        bit hit;
        n_cmp       = 0;
        n_bad       = 0;
        reset       = 1'b1;
        start       = 1'b0;
        mon_clr     = 1'b0;
        base_tab[0] = BaseA;
        base_tab[1] = BaseB;
        max_tab[0]  = MaxA;
        max_tab[1]  = MaxB;

        // Directed load: 11 22 33 44, done at 3; instance B stalls 3 cycles on write 1.
        for (int i = 0; i < 64; i++) begin
            rom_mem[i]      = 8'($urandom);
            stall_tab[0][i] = 0;
            stall_tab[1][i] = 0;
        end
        rom_mem[0]      = 8'h11;
        rom_mem[1]      = 8'h22;
        rom_mem[2]      = 8'h33;
        rom_mem[3]      = 8'h44;
        last_idx[0]     = 32'd3;
        last_idx[1]     = 32'd3;
        stall_tab[1][1] = 3;

        repeat (3) @(posedge clk);
        #2;
        check_reset_state("reset");
        release_reset();
        wait_end(200);
        check_result();
        check_eq("directed_sum_a", {24'd0, checksum_a}, 32'hAA);

        // Reload the same image from DONE; a start pulse mid-load must be ignored.
        stall_tab[1][1] = 0;
        stall_tab[0][2] = 2;
        start_load();
        repeat (2) @(posedge clk);
        #2;
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        wait_end(200);
        check_result();

        // Instance B never sees rom_done: stops with ERROR after exactly 8 writes.
        last_idx[1] = 32'd1000;
        start_load();
        wait_end(400);
        check_result();

        // Random images, done positions and stall patterns.
        for (int it = 0; it < 6; it++) begin
            randomize_load(40, 12);
            start_load();
            wait_end(1000);
            check_result();
        end

        // Reset while instance A is writing byte 2, then the automatic reload from 0.
        randomize_load(30, 12);
        last_idx[0] = 32'd20;
        start_load();
        hit = 1'b0;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(posedge clk);
            #2;
            hit = (acc[0] == 2) && we_a;
        end
        check_eq("reach_write2", {31'd0, hit}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #2;
        check_reset_state("abort");
        release_reset();
        wait_end(1000);
        check_result();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 SHALL have parameter RAM_BASE, default 32'd0: RAM byte address that receives ROM byte 0.
REQ-002 SHALL have parameter MAX_BYTES, default 32'd65536: byte limit; reaching it without rom_done is an error.
REQ-003 SHALL have parameter AUTO_START, default 1: when 1, a load begins automatically after reset.
REQ-004 SHALL have port clock  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle pulse that requests a (re)load; honoured only in IDLE, DONE or ERROR.
REQ-007 SHALL have port rom_address  output  32  byte address driven to the ROM.
REQ-008 SHALL have port rom_byte  input  8  combinational ROM data for rom_address.
REQ-009 SHALL have port rom_done  input  1  high when rom_address is the final ROM byte.
REQ-010 SHALL have port ram_address  output  32  RAM write byte address.
REQ-011 SHALL have port ram_data  output  8  RAM write data.
REQ-012 SHALL have port ram_write_enable  output  1  write request to RAM.
REQ-013 SHALL have port ram_ready  input  1  RAM accepts the write in any cycle where ram_write_enable and ram_ready are both high.
REQ-014 SHALL have port cpu_reset  output  1  holds the CPU in reset until the load completes.
REQ-015 SHALL have port load_done  output  1  load completed successfully.
REQ-016 SHALL have port load_error  output  1  MAX_BYTES reached without rom_done.
REQ-017 SHALL have port byte_count  output  32  number of bytes written to RAM in the current load.
REQ-018 SHALL have port checksum  output  8  modulo-256 sum of all bytes written in the current load.

Function
REQ-019 SHALL implement a state machine with states IDLE, FETCH, WRITE, DONE and ERROR.
REQ-020 SHALL drive rom_address = byte_count combinationally in every state.
REQ-021 In FETCH, SHALL register rom_byte into a data register and rom_done into a last flag, then go to WRITE on the next edge; FETCH lasts exactly one cycle.
REQ-022 In WRITE, SHALL hold ram_write_enable=1, ram_address=RAM_BASE+byte_count (32-bit wrap) and ram_data=data register, stable until ram_ready is high.
REQ-023 On a WRITE cycle with ram_ready=1, SHALL increment byte_count and add the data register to checksum (8-bit wrap) in the same edge.
REQ-024 On that same edge, SHALL go to DONE if the last flag is set, else to ERROR if the incremented byte_count equals MAX_BYTES, else to FETCH.
REQ-025 The byte at the address where rom_done is high SHALL be written; it is the final byte (total bytes = done address + 1).
REQ-026 Throughput SHALL be one byte per 2 cycles when ram_ready is held high; each cycle ram_ready is low adds one cycle.
REQ-027 ram_write_enable SHALL be 0 in every state other than WRITE.
REQ-028 cpu_reset SHALL be 1 in IDLE, FETCH, WRITE and ERROR, and 0 only in DONE.
REQ-029 load_done SHALL be 1 only in DONE; load_error SHALL be 1 only in ERROR.
REQ-030 IDLE SHALL go to FETCH on start=1, and SHALL go to FETCH unconditionally on the first cycle after reset when AUTO_START=1.
REQ-031 start in DONE or ERROR SHALL clear byte_count and checksum and go to FETCH on the same edge, reasserting cpu_reset from that edge.
REQ-032 start during FETCH or WRITE SHALL be ignored.
REQ-033 A rom_done input that goes high while ram_ready is low SHALL have no effect; only the value registered in FETCH counts.

Reset
REQ-034 On reset=1 at a clock edge, SHALL enter IDLE with byte_count=0, checksum=0, data register=0, last flag=0, ram_write_enable=0, cpu_reset=1, load_done=0, load_error=0.
REQ-035 Reset SHALL take priority over start and ram_ready, and SHALL abort a load in progress with no further RAM write issued.

Verification
REQ-036 Stub ROM bytes 0x11,0x22,0x33,0x44 with rom_done at address 3, ram_ready=1, AUTO_START=1 -> exactly 4 writes to addresses 0..3; load_done and cpu_reset=0 from cycle 9 after reset; byte_count=4; checksum=0xAA.
REQ-037 Same stimulus with RAM_BASE=0x100 and ram_ready low for 3 cycles on the second write -> writes go to addresses 0x100..0x103, the second write's address and data are held stable, and load_done is delayed by exactly 3 cycles.
REQ-038 rom_done never high, MAX_BYTES=8 -> 8 writes, then load_error=1, cpu_reset=1, byte_count=8, and no further writes.
REQ-039 reset asserted during the WRITE of byte 2 -> state IDLE, byte_count=0, checksum=0 next cycle; with AUTO_START=1 the load restarts from address 0.
REQ-040 start pulsed in DONE -> cpu_reset=1 on the same edge, the ROM is reloaded, and the final checksum is identical; start pulsed mid-load is ignored.
